// File: rtl/md_pkg.sv
// Shared MD definitions: transfer legality, byte-count width and the packer FSM states.
package md_pkg;

  // Packer control states: empty, partially filled, flush waiting for the output register.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } md_state_e;

  // Width of a byte count that must represent 0..nb inclusive.
  function automatic int md_cnt_w(input int nb);
    return $clog2(nb) + 1;
  endfunction

  // A transfer is usable only if it carries at least one byte and stays inside the word.
  function automatic logic md_legal(input int unsigned offset,
                                    input int unsigned size,
                                    input int unsigned nb);
    return (size != 0) && ((offset + size) <= nb);
  endfunction

endpackage

// File: rtl/md_lane_shifter.sv
// Combinational byte-lane extractor: appends lanes offset..offset+size-1 of the incoming
// word after the first `fill` bytes of the accumulator. The result is a double-width
// window: `lo` is the (possibly completed) word, `hi` holds the overflow bytes.
module md_lane_shifter
  import md_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]               in_data,
  input  logic [$clog2(DATA_W/8)-1:0]     offset,
  input  logic [$clog2(DATA_W/8):0]       size,
  input  logic [DATA_W-1:0]               acc,
  input  logic [$clog2(DATA_W/8)-1:0]     fill,
  output logic [DATA_W-1:0]               lo,
  output logic [DATA_W-1:0]               hi
);

  localparam int NB = DATA_W / 8;

  logic [7:0] win [2*NB];
  int         f;
  int         o;
  int         s;

  // Build the 2*NB byte window: accumulator bytes first, then the selected input lanes.
  always_comb begin
    f = int'(fill);
    o = int'(offset);
    s = int'(size);
    for (int p = 0; p < 2*NB; p++) begin
      win[p] = 8'h00;
    end
    for (int p = 0; p < NB; p++) begin
      if (p < f) begin
        win[p] = acc[8*p +: 8];
      end
    end
    for (int p = 0; p < 2*NB; p++) begin
      for (int l = 0; l < NB; l++) begin
        if ((p >= f) && (p < f + s) && (l + f == p + o)) begin
          win[p] = in_data[8*l +: 8];
        end
      end
    end
  end

  // Split the window into the current word and the leftover bytes.
  always_comb begin
    lo = '0;
    hi = '0;
    for (int p = 0; p < NB; p++) begin
      lo[8*p +: 8] = win[p];
      hi[8*p +: 8] = win[p+NB];
    end
  end

endmodule

// File: rtl/md_byte_packer.sv
// MD byte packer: gathers variable-offset/variable-size MD transfers into dense
// little-endian words, with a flush request to emit a partial word.
// Optional statistics counters are enabled by defining MD_BYTE_PACKER_STATS_EN.
module md_byte_packer
  import md_pkg::*;
#(
  parameter int ALGN_DATA_WIDTH = 32
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   md_rx_valid,
  input  logic [ALGN_DATA_WIDTH-1:0]             md_rx_data,
  input  logic [$clog2(ALGN_DATA_WIDTH/8)-1:0]   md_rx_offset,
  input  logic [$clog2(ALGN_DATA_WIDTH/8):0]     md_rx_size,
  output logic                                   md_rx_ready,
  output logic                                   md_rx_err,
  input  logic                                   flush,
  output logic                                   out_valid,
  output logic [ALGN_DATA_WIDTH-1:0]             out_data,
  output logic [$clog2(ALGN_DATA_WIDTH/8):0]     out_bytes,
  input  logic                                   out_ready,
  output logic [15:0]                            cnt_words,
  output logic [15:0]                            cnt_err
);

  localparam int NB = ALGN_DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = md_cnt_w(NB);

  md_state_e                  state;
  md_state_e                  state_next;
  logic [ALGN_DATA_WIDTH-1:0] acc;
  logic [ALGN_DATA_WIDTH-1:0] acc_next;
  logic [OW-1:0]              fill;
  logic [OW-1:0]              fill_next;
  logic [ALGN_DATA_WIDTH-1:0] shift_lo;
  logic [ALGN_DATA_WIDTH-1:0] shift_hi;
  logic [CW:0]                sum;
  logic                       legal;
  logic                       take;
  logic                       complete;
  logic                       out_free;
  logic                       flush_pending;
  logic                       load_word;
  logic [ALGN_DATA_WIDTH-1:0] ld_data;
  logic [CW-1:0]              ld_bytes;

  assign legal         = md_legal(32'(md_rx_offset), 32'(md_rx_size), NB);
  assign md_rx_err     = md_rx_valid & ~legal;
  assign out_free      = ~out_valid | out_ready;
  assign flush_pending = (state == FLUSH);
  assign md_rx_ready   = reset_n & out_free & ~flush_pending & ~flush;
  assign take          = md_rx_valid & md_rx_ready & legal;
  assign sum           = (CW+1)'(fill) + (CW+1)'(md_rx_size);
  assign complete      = (sum >= (CW+1)'(NB));

  md_lane_shifter #(
    .DATA_W (ALGN_DATA_WIDTH)
  ) u_shifter (
    .in_data (md_rx_data),
    .offset  (md_rx_offset),
    .size    (md_rx_size),
    .acc     (acc),
    .fill    (fill),
    .lo      (shift_lo),
    .hi      (shift_hi)
  );

  // Next-state logic: accumulate/complete words, or resolve a pending flush.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    fill_next  = fill;
    load_word  = 1'b0;
    ld_data    = acc;
    ld_bytes   = '0;
    case (state)
      FLUSH: begin
        if (fill == '0) begin
          state_next = flush ? FLUSH : IDLE;
        end else if (out_free) begin
          load_word  = 1'b1;
          ld_data    = acc;
          ld_bytes   = CW'(fill);
          acc_next   = '0;
          fill_next  = '0;
          state_next = flush ? FLUSH : IDLE;
        end
      end
      default: begin
        if (take) begin
          if (complete) begin
            load_word = 1'b1;
            ld_data   = shift_lo;
            ld_bytes  = CW'(NB);
            acc_next  = shift_hi;
            fill_next = OW'(sum - (CW+1)'(NB));
          end else begin
            acc_next  = shift_lo;
            fill_next = OW'(sum);
          end
        end
        if (flush) begin
          state_next = FLUSH;
        end else begin
          state_next = (fill_next != '0) ? ACCUM : IDLE;
        end
      end
    endcase
  end

  // State, fill level and accumulator registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      fill  <= '0;
      acc   <= '0;
    end else begin
      state <= state_next;
      fill  <= fill_next;
      acc   <= acc_next;
    end
  end

  // Output register: held until accepted, reloadable in the accepting cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bytes <= '0;
    end else if (load_word) begin
      out_valid <= 1'b1;
      out_data  <= ld_data;
      out_bytes <= ld_bytes;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MD_BYTE_PACKER_STATS_EN
  logic [15:0] cnt_words_q;
  logic [15:0] cnt_err_q;
  logic        bad_xfer;

  assign bad_xfer  = md_rx_valid & md_rx_ready & ~legal;
  assign cnt_words = cnt_words_q;
  assign cnt_err   = cnt_err_q;

  // Saturating counts of emitted words and dropped illegal transfers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_words_q <= '0;
      cnt_err_q   <= '0;
    end else begin
      if (load_word && (cnt_words_q != 16'hFFFF)) begin
        cnt_words_q <= cnt_words_q + 16'd1;
      end
      if (bad_xfer && (cnt_err_q != 16'hFFFF)) begin
        cnt_err_q <= cnt_err_q + 16'd1;
      end
    end
  end
`else
  assign cnt_words = 16'd0;
  assign cnt_err   = 16'd0;
`endif

endmodule

// File: doc/md_byte_packer.md
MD_BYTE_PACKER -- requirements
Module: md_byte_packer

Interface
REQ-001 The block SHALL have parameter ALGN_DATA_WIDTH, default 32, MD data width in bits; a power of two and at least 8; NB = ALGN_DATA_WIDTH/8 bytes.
REQ-002 The block SHALL have port clk, input, 1, single clock, all logic on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have port md_rx_valid, input, 1, MD transfer valid (driven by the aligner MD TX side).
REQ-005 The block SHALL have port md_rx_data, input, ALGN_DATA_WIDTH, MD data, byte lane i = bits 8i+7:8i.
REQ-006 The block SHALL have port md_rx_offset, input, $clog2(NB), first valid byte lane.
REQ-007 The block SHALL have port md_rx_size, input, $clog2(NB)+1, number of valid bytes.
REQ-008 The block SHALL have port md_rx_ready, output, 1, transfer accepted when valid and ready are both high.
REQ-009 The block SHALL have port md_rx_err, output, 1, illegal-transfer flag.
REQ-010 The block SHALL have port flush, input, 1, request to emit a partial word.
REQ-011 The block SHALL have port out_valid, output, 1, packed word valid.
REQ-012 The block SHALL have port out_data, output, ALGN_DATA_WIDTH, packed word.
REQ-013 The block SHALL have port out_bytes, output, $clog2(NB)+1, count of valid bytes in out_data (1..NB).
REQ-014 The block SHALL have port out_ready, input, 1, downstream accept.
REQ-015 The block SHALL have ports cnt_words and cnt_err, outputs, 16 each, statistics counters.

Function
REQ-016 A transfer SHALL be legal iff size>0 and offset+size<=NB; md_rx_err SHALL be combinational = md_rx_valid & !legal.
REQ-017 An illegal transfer SHALL still complete the handshake and SHALL be dropped, leaving the accumulator unchanged.
REQ-018 md_rx_ready SHALL be (!out_valid | out_ready) & !flush_pending & !flush.
REQ-019 Legal bytes from lanes offset..offset+size-1 SHALL be appended in ascending lane order at accumulator position fill (fill range 0..NB-1).
REQ-020 If fill+size>=NB, the completed word SHALL be loaded into the output register, with out_valid high on the next cycle and out_bytes=NB; the fill+size-NB leftover bytes SHALL go to accumulator positions 0.., with fill set to fill+size-NB.
REQ-021 Output byte k SHALL be the k-th byte received after the previous emitted word (little-endian packing); unfilled bytes SHALL be zero.
REQ-022 out_valid, out_data and out_bytes SHALL be held stable until out_ready; a word and a new word load in the same cycle SHALL be allowed (back-to-back throughput of 1 word per cycle).
REQ-023 flush high for one cycle SHALL set flush_pending; when the output register is free and fill>0, the block SHALL emit a word with out_bytes=fill, then clear fill and flush_pending.
REQ-024 A flush with fill=0 SHALL clear flush_pending without emitting.
REQ-025 The control FSM SHALL have states IDLE (fill=0, no pending flush), ACCUM (fill>0) and FLUSH (flush_pending), with transitions as in REQ-020, REQ-023 and REQ-024.

Reset
REQ-026 While reset_n=0 at a rising clk, fill, accumulator, flush_pending, out_valid, out_data, out_bytes and counters SHALL clear to 0 and the FSM SHALL go to IDLE; reset mid-word SHALL discard partial data.
REQ-027 During reset md_rx_ready SHALL be 0.

Configuration
REQ-028 With MD_BYTE_PACKER_STATS_EN defined, cnt_words SHALL count emitted words and cnt_err SHALL count illegal transfers, both saturating at 16'hFFFF.
REQ-029 Without MD_BYTE_PACKER_STATS_EN, cnt_words and cnt_err SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-030 A shared package md_pkg SHALL hold the MD legality function, the byte-count type width function and the FSM state enum.
REQ-031 Byte-lane extraction and shift into the accumulator SHALL be one sub-module, md_lane_shifter (purely combinational); everything else stays in md_byte_packer.

Verification (ALGN_DATA_WIDTH=32, NB=4)
REQ-032 1-byte transfers 0x11@0, 0x22@1, 0x33@2, 0x44@3 -> out_data=0x44332211, out_bytes=4, out_valid one cycle after the 4th handshake.
REQ-033 0xAABBCC00 off1 size3 then 0x0000EEDD off0 size2 -> out_data=0xDDAABBCC; fill=1 holding 0xEE.
REQ-034 Offset 2, size 3 -> md_rx_err=1 in the handshake cycle, fill unchanged, cnt_err=1 (STATS_EN).
REQ-035 out_ready=0 with out_valid=1 -> md_rx_ready=0 and output stable for 10 cycles; out_ready=1 -> the word is accepted and input resumes the same cycle.
REQ-036 fill=2 (0xBB,0xAA) plus a flush pulse -> out_data=0x0000AABB, out_bytes=2, then fill=0.
REQ-037 fill=3 plus reset_n low for one cycle -> out_valid=0, fill=0; the next 4 bytes form a fresh word.
